// File: rtl/tmip_gray_loader.sv
// TMIP input stage: streams pixel-major/channel-minor samples and writes
// max, average and weighted grayscale planes one pixel per strobe.
//
// state | meaning
// IDLE  | waiting for in_valid; first sample of a frame is consumed here
// LOAD  | accumulating channels and emitting one write per pixel
// SKIP  | draining an unsupported-size stream until in_valid drops
module tmip_gray_loader #(
  parameter int DW         = 8,
  parameter int CH         = 3,
  parameter int MAX_N_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DW-1:0]             image,
  input  logic [1:0]                image_size,
  output logic                      wr_en,
  output logic [2*MAX_N_LOG2-1:0]   wr_addr,
  output logic [DW-1:0]             gray_max,
  output logic [DW-1:0]             gray_avg,
  output logic [DW-1:0]             gray_wgt,
  output logic [1:0]                size_out,
  output logic                      done,
  output logic                      err
);

  localparam int AW = 2*MAX_N_LOG2;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int SW = DW + $clog2(CH);
  localparam logic [CW-1:0] CH_LAST = CW'(CH-1);
  localparam logic [SW-1:0] CH_DIV  = SW'(CH);

  typedef enum logic [1:0] {IDLE, LOAD, SKIP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   ch_cnt, cur_ch;
  logic [AW-1:0]   pix_cnt, cur_pix, last_pix;
  logic [1:0]      cur_k;
  logic [DW-1:0]   max_r, max_n, wgt_r, wgt_n, avg_n;
  logic [SW-1:0]   sum_r, sum_n;
  logic            size_ok, accept, first, last_ch, frame_end;

  // Weighted terms only exist for the 3-channel build; other builds reuse avg.
  function automatic logic [DW-1:0] wgt_term(input logic [CW-1:0] c, input logic [DW-1:0] d);
    if (CH != 3) return '0;
    if (c == CW'(1)) return d >> 1;
    return d >> 2;
  endfunction

  always_comb begin
    size_ok  = int'(image_size) <= (MAX_N_LOG2 - 2);
    cur_ch   = '0;
    cur_pix  = '0;
    cur_k    = image_size;
    if (state == LOAD) begin
      cur_ch  = ch_cnt;
      cur_pix = pix_cnt;
      cur_k   = size_out;
    end
    accept    = in_valid && (((state == IDLE) && size_ok) || (state == LOAD));
    first     = (cur_ch == '0);
    last_ch   = (cur_ch == CH_LAST);
    last_pix  = AW'((1 << (2*int'(cur_k) + 4)) - 1);
    frame_end = accept && last_ch && (cur_pix == last_pix);
    max_n     = (first || (image > max_r)) ? image : max_r;
    sum_n     = first ? SW'(image) : sum_r + SW'(image);
    wgt_n     = first ? wgt_term(cur_ch, image) : wgt_r + wgt_term(cur_ch, image);
    avg_n     = DW'(sum_n / CH_DIV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!size_ok)       state_n = SKIP;
          else if (frame_end) state_n = IDLE;
          else                state_n = LOAD;
        end
      end
      LOAD: begin
        if (!in_valid || frame_end) state_n = IDLE;
      end
      SKIP: begin
        if (!in_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt   <= '0;
      pix_cnt  <= '0;
      max_r    <= '0;
      sum_r    <= '0;
      wgt_r    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      gray_max <= '0;
      gray_avg <= '0;
      gray_wgt <= '0;
      size_out <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= ((state == IDLE) && in_valid && !size_ok) || ((state == LOAD) && !in_valid);
      if ((state == IDLE) && in_valid && size_ok) size_out <= image_size;
      if (accept) begin
        max_r <= max_n;
        sum_r <= sum_n;
        wgt_r <= wgt_n;
        if (last_ch) begin
          ch_cnt   <= '0;
          pix_cnt  <= cur_pix + 1'b1;
          wr_en    <= 1'b1;
          wr_addr  <= cur_pix;
          gray_max <= max_n;
          gray_avg <= avg_n;
          gray_wgt <= (CH == 3) ? wgt_n : avg_n;
          done     <= (cur_pix == last_pix);
        end else begin
          ch_cnt  <= cur_ch + 1'b1;
          pix_cnt <= cur_pix;
        end
      end else begin
        // Abort or idle: any partial pixel is dropped here.
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmip_gray_loader.sv
// Directed bench for tmip_gray_loader: default 3-channel build plus a
// 4-channel 10-bit build for width and mid-frame reset behaviour.
module tb_tmip_gray_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid;
  logic [7:0] image;
  logic [1:0] image_size;
  logic       wr_en, done, err;
  logic [7:0] wr_addr, gray_max, gray_avg, gray_wgt;
  logic [1:0] size_out;

  logic       rst4_n, in4_valid;
  logic [9:0] image4;
  logic [1:0] size4;
  logic       wr_en4, done4, err4;
  logic [7:0] wr_addr4;
  logic [9:0] gmax4, gavg4, gwgt4;
  logic [1:0] size4_out;

  tmip_gray_loader u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .image(image), .image_size(image_size),
    .wr_en(wr_en), .wr_addr(wr_addr), .gray_max(gray_max), .gray_avg(gray_avg),
    .gray_wgt(gray_wgt), .size_out(size_out), .done(done), .err(err));

  tmip_gray_loader #(.DW(10), .CH(4), .MAX_N_LOG2(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in4_valid), .image(image4), .image_size(size4),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .gray_max(gmax4), .gray_avg(gavg4),
    .gray_wgt(gwgt4), .size_out(size4_out), .done(done4), .err(err4));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {int cyc; int addr; int mx; int av; int wg; bit dn;} wr_t;
  wr_t wq[$];
  wr_t wq4[$];
  int  errq[$];
  int  done_n = 0;
  int  done4_n = 0;
  int  err4_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (wr_en) begin
      w.cyc = cyc; w.addr = int'(wr_addr); w.mx = int'(gray_max);
      w.av = int'(gray_avg); w.wg = int'(gray_wgt); w.dn = done;
      wq.push_back(w);
    end
    if (done) done_n++;
    if (err) errq.push_back(cyc);
    if (wr_en4) begin
      w.cyc = cyc; w.addr = int'(wr_addr4); w.mx = int'(gmax4);
      w.av = int'(gavg4); w.wg = int'(gwgt4); w.dn = done4;
      wq4.push_back(w);
    end
    if (done4) done4_n++;
    if (err4) err4_n++;
  end

  task automatic drive(input logic v, input logic [1:0] k, input logic [7:0] d);
    @(posedge clk); #1;
    in_valid = v; image_size = k; image = d;
  endtask

  task automatic drive4(input logic v, input logic [1:0] k, input logic [9:0] d);
    @(posedge clk); #1;
    in4_valid = v; size4 = k; image4 = d;
  endtask

  task automatic clear_logs;
    wq.delete(); errq.delete(); done_n = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; rst4_n = 1'b1;
    in_valid = 0; image = 0; image_size = 0;
    in4_valid = 0; image4 = 0; size4 = 0;
    #2 rst_n = 1'b0; rst4_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    n_checks++; if (wr_addr !== 8'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    n_checks++; if ({gray_max, gray_avg, gray_wgt} !== 24'd0) begin n_fail++; $display("FAIL reset_gray: got %h expected 0", {gray_max, gray_avg, gray_wgt}); end
    n_checks++; if (size_out !== 2'd0) begin n_fail++; $display("FAIL reset_size_out: got %0d expected 0", size_out); end
    n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b expected 00", {done, err}); end
    n_checks++; if ({wr_en4, done4, err4, gmax4} !== 13'd0) begin n_fail++; $display("FAIL reset_dut4: got %h expected 0", {wr_en4, done4, err4, gmax4}); end
    rst_n = 1'b1; rst4_n = 1'b1;
    repeat (2) drive(0, 0, 0);
    @(negedge clk);
    n_checks++; if ({wr_en, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_release: got %b expected 000", {wr_en, done, err}); end
  endtask

  task automatic test_uniform;
    clear_logs();
    for (int p = 0; p < 16; p++) begin
      drive(1, 0, 8'd10); drive(1, 0, 8'd20); drive(1, 0, 8'd30);
    end
    repeat (4) drive(0, 0, 0);
    n_checks++; if (wq.size() != 16) begin n_fail++; $display("FAIL uniform_count: got %0d expected 16", wq.size()); end
    for (int i = 0; i < wq.size(); i++) begin
      n_checks++; if (wq[i].addr != i) begin n_fail++; $display("FAIL uniform_addr[%0d]: got %0d expected %0d", i, wq[i].addr, i); end
      n_checks++; if (wq[i].mx != 30 || wq[i].av != 20 || wq[i].wg != 19) begin n_fail++; $display("FAIL uniform_data[%0d]: got %0d/%0d/%0d expected 30/20/19", i, wq[i].mx, wq[i].av, wq[i].wg); end
      n_checks++; if (wq[i].dn != (i == 15)) begin n_fail++; $display("FAIL uniform_done[%0d]: got %0d expected %0d", i, wq[i].dn, i == 15); end
      if (i > 0) begin
        n_checks++; if (wq[i].cyc - wq[i-1].cyc != 3) begin n_fail++; $display("FAIL uniform_cadence[%0d]: got %0d expected 3", i, wq[i].cyc - wq[i-1].cyc); end
      end
    end
    n_checks++; if (done_n != 1) begin n_fail++; $display("FAIL uniform_done_count: got %0d expected 1", done_n); end
    n_checks++; if (errq.size() != 0) begin n_fail++; $display("FAIL uniform_err: got %0d expected 0", errq.size()); end
    n_checks++; if (size_out !== 2'd0) begin n_fail++; $display("FAIL uniform_size_out: got %0d expected 0", size_out); end
  endtask

  task automatic test_extremes;
    clear_logs();
    drive(1, 0, 8'd255); drive(1, 0, 8'd255); drive(1, 0, 8'd255);
    drive(1, 0, 8'd0);   drive(1, 0, 8'd0);   drive(1, 0, 8'd1);
    for (int s = 0; s < 42; s++) drive(1, 0, 8'd0);
    repeat (4) drive(0, 0, 0);
    n_checks++; if (wq.size() != 16) begin n_fail++; $display("FAIL extremes_count: got %0d expected 16", wq.size()); end
    if (wq.size() >= 2) begin
      n_checks++; if (wq[0].mx != 255 || wq[0].av != 255 || wq[0].wg != 253) begin n_fail++; $display("FAIL extremes_px0: got %0d/%0d/%0d expected 255/255/253", wq[0].mx, wq[0].av, wq[0].wg); end
      n_checks++; if (wq[1].mx != 1 || wq[1].av != 0 || wq[1].wg != 0) begin n_fail++; $display("FAIL extremes_px1: got %0d/%0d/%0d expected 1/0/0", wq[1].mx, wq[1].av, wq[1].wg); end
    end
  endtask

  task automatic test_bad_size;
    int c0;
    clear_logs();
    drive(1, 3, 8'd5);
    c0 = cyc;
    for (int s = 0; s < 19; s++) drive(1, 3, 8'(s));
    repeat (4) drive(0, 0, 0);
    n_checks++; if (errq.size() != 1) begin n_fail++; $display("FAIL badsize_err_count: got %0d expected 1", errq.size()); end
    if (errq.size() >= 1) begin
      n_checks++; if (errq[0] != c0 + 1) begin n_fail++; $display("FAIL badsize_err_time: got %0d expected %0d", errq[0], c0 + 1); end
    end
    n_checks++; if (wq.size() != 0) begin n_fail++; $display("FAIL badsize_writes: got %0d expected 0", wq.size()); end
    n_checks++; if (done_n != 0) begin n_fail++; $display("FAIL badsize_done: got %0d expected 0", done_n); end
    n_checks++; if (size_out !== 2'd0) begin n_fail++; $display("FAIL badsize_size_out: got %0d expected 0", size_out); end
  endtask

  task automatic test_abort;
    int c0;
    clear_logs();
    for (int s = 0; s < 100; s++) drive(1, 1, 8'(s));
    drive(0, 0, 0);
    c0 = cyc;
    repeat (4) drive(0, 0, 0);
    n_checks++; if (wq.size() != 33) begin n_fail++; $display("FAIL abort_count: got %0d expected 33", wq.size()); end
    for (int p = 0; p < wq.size(); p++) begin
      n_checks++; if (wq[p].addr != p) begin n_fail++; $display("FAIL abort_addr[%0d]: got %0d expected %0d", p, wq[p].addr, p); end
      n_checks++;
      if (wq[p].mx != 3*p+2 || wq[p].av != 3*p+1 ||
          wq[p].wg != ((3*p) >> 2) + ((3*p+1) >> 1) + ((3*p+2) >> 2)) begin
        n_fail++;
        $display("FAIL abort_data[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", p, wq[p].mx, wq[p].av, wq[p].wg,
                 3*p+2, 3*p+1, ((3*p) >> 2) + ((3*p+1) >> 1) + ((3*p+2) >> 2));
      end
    end
    n_checks++; if (errq.size() != 1) begin n_fail++; $display("FAIL abort_err_count: got %0d expected 1", errq.size()); end
    if (errq.size() >= 1) begin
      n_checks++; if (errq[0] != c0 + 1) begin n_fail++; $display("FAIL abort_err_time: got %0d expected %0d", errq[0], c0 + 1); end
    end
    n_checks++; if (done_n != 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", done_n); end
    n_checks++; if (size_out !== 2'd1) begin n_fail++; $display("FAIL abort_size_out: got %0d expected 1", size_out); end

    clear_logs();
    for (int s = 0; s < 48; s++) drive(1, 0, 8'd7);
    repeat (4) drive(0, 0, 0);
    n_checks++; if (wq.size() != 16) begin n_fail++; $display("FAIL recover_count: got %0d expected 16", wq.size()); end
    if (wq.size() == 16) begin
      n_checks++; if (wq[15].addr != 15 || !wq[15].dn) begin n_fail++; $display("FAIL recover_last: got addr %0d done %0d expected 15/1", wq[15].addr, wq[15].dn); end
      n_checks++; if (wq[0].addr != 0 || wq[0].mx != 7 || wq[0].av != 7 || wq[0].wg != 5) begin n_fail++; $display("FAIL recover_px0: got %0d:%0d/%0d/%0d expected 0:7/7/5", wq[0].addr, wq[0].mx, wq[0].av, wq[0].wg); end
    end
    n_checks++; if (done_n != 1 || errq.size() != 0) begin n_fail++; $display("FAIL recover_flags: got done %0d err %0d expected 1/0", done_n, errq.size()); end
    n_checks++; if (size_out !== 2'd0) begin n_fail++; $display("FAIL recover_size_out: got %0d expected 0", size_out); end
  endtask

  task automatic test_back_to_back;
    clear_logs();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) begin
        drive(1, 0, 8'(4*i)); drive(1, 0, 8'(8*i)); drive(1, 0, 8'(12*i));
      end
    repeat (4) drive(0, 0, 0);
    n_checks++; if (wq.size() != 32) begin n_fail++; $display("FAIL b2b_count: got %0d expected 32", wq.size()); end
    for (int j = 0; j < wq.size(); j++) begin
      n_checks++; if (wq[j].addr != j % 16) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", j, wq[j].addr, j % 16); end
      n_checks++; if (wq[j].mx != 12*(j%16) || wq[j].av != 8*(j%16) || wq[j].wg != 8*(j%16)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", j, wq[j].mx, wq[j].av, wq[j].wg, 12*(j%16), 8*(j%16), 8*(j%16)); end
      n_checks++; if (wq[j].dn != (j % 16 == 15)) begin n_fail++; $display("FAIL b2b_done[%0d]: got %0d expected %0d", j, wq[j].dn, j % 16 == 15); end
      if (j > 0) begin
        n_checks++; if (wq[j].cyc - wq[j-1].cyc != 3) begin n_fail++; $display("FAIL b2b_cadence[%0d]: got %0d expected 3", j, wq[j].cyc - wq[j-1].cyc); end
      end
    end
    n_checks++; if (done_n != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_n); end
    n_checks++; if (errq.size() != 0) begin n_fail++; $display("FAIL b2b_err: got %0d expected 0", errq.size()); end
  endtask

  task automatic test_ch4_reset;
    wq4.delete(); done4_n = 0; err4_n = 0;
    drive4(1, 1, 10'd1023); drive4(1, 1, 10'd0); drive4(1, 1, 10'd0); drive4(1, 1, 10'd1);
    drive4(1, 1, 10'd4); drive4(1, 1, 10'd8); drive4(1, 1, 10'd12); drive4(1, 1, 10'd100);
    drive4(1, 1, 10'd1); drive4(1, 1, 10'd2); drive4(1, 1, 10'd3); drive4(1, 1, 10'd4);
    drive4(1, 1, 10'd9); drive4(1, 1, 10'd9);
    @(negedge clk);
    n_checks++; if (wq4.size() != 3) begin n_fail++; $display("FAIL ch4_count: got %0d expected 3", wq4.size()); end
    if (wq4.size() == 3) begin
      n_checks++; if (wq4[0].mx != 1023 || wq4[0].av != 256 || wq4[0].wg != 256) begin n_fail++; $display("FAIL ch4_px0: got %0d/%0d/%0d expected 1023/256/256", wq4[0].mx, wq4[0].av, wq4[0].wg); end
      n_checks++; if (wq4[1].mx != 100 || wq4[1].av != 31 || wq4[1].wg != 31) begin n_fail++; $display("FAIL ch4_px1: got %0d/%0d/%0d expected 100/31/31", wq4[1].mx, wq4[1].av, wq4[1].wg); end
      n_checks++; if (wq4[2].addr != 2 || wq4[2].mx != 4 || wq4[2].av != 2 || wq4[2].wg != 2) begin n_fail++; $display("FAIL ch4_px2: got %0d:%0d/%0d/%0d expected 2:4/2/2", wq4[2].addr, wq4[2].mx, wq4[2].av, wq4[2].wg); end
    end
    n_checks++; if (wr_addr4 !== 8'd2 || size4_out !== 2'd1) begin n_fail++; $display("FAIL ch4_held: got addr %0d size %0d expected 2/1", wr_addr4, size4_out); end
    #2 rst4_n = 1'b0; in4_valid = 1'b0;
    #1;
    n_checks++; if ({wr_en4, done4, err4} !== 3'b000 || wr_addr4 !== 8'd0) begin n_fail++; $display("FAIL midreset_ctrl: got %b addr %0d expected 000/0", {wr_en4, done4, err4}, wr_addr4); end
    n_checks++; if ({gmax4, gavg4, gwgt4} !== 30'd0 || size4_out !== 2'd0) begin n_fail++; $display("FAIL midreset_data: got %h size %0d expected 0/0", {gmax4, gavg4, gwgt4}, size4_out); end
    #3 rst4_n = 1'b1;
    repeat (6) drive4(0, 0, 0);
    n_checks++; if (done4_n != 0 || err4_n != 0) begin n_fail++; $display("FAIL midreset_flags: got done %0d err %0d expected 0/0", done4_n, err4_n); end
    n_checks++; if (wq4.size() != 3) begin n_fail++; $display("FAIL midreset_writes: got %0d expected 3", wq4.size()); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_extremes();
    test_bad_size();
    test_abort();
    test_back_to_back();
    test_ch4_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
